// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, the handshake
// FSM state type and opcode classification.
package seq_alu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_MUL = 5'b00010;
    localparam logic [4:0] OP_DIV = 5'b00011;
    localparam logic [4:0] OP_INC = 5'b00100;
    localparam logic [4:0] OP_DEC = 5'b00101;
    localparam logic [4:0] OP_AND = 5'b00110;
    localparam logic [4:0] OP_OR  = 5'b00111;
    localparam logic [4:0] OP_XOR = 5'b01000;
    localparam logic [4:0] OP_NOT = 5'b01001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // MUL and DIV run on the iterative unit; everything else is single-cycle.
    function automatic logic is_iterative(input logic [31:0] op);
        return (op == 32'(OP_MUL)) || (op == 32'(OP_DIV));
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider sharing one 2*WIDTH
// accumulator. The first iteration is performed on the start edge so the
// final value is ready one edge before the top-level counter expires.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               div_q, div_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] base;
    logic [WIDTH-1:0]   opb;
    logic               mode;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_rs;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic [2*WIDTH-1:0] step;

    // One multiply or divide iteration on either fresh operands or the accumulator.
    always_comb begin
        base = start ? {{WIDTH{1'b0}}, a} : acc_q;
        opb  = start ? b : b_q;
        mode = start ? is_div : div_q;

        // Multiply: low half holds the multiplier, high half the partial product.
        mul_sum  = {1'b0, base[2*WIDTH-1:WIDTH]} + (base[0] ? {1'b0, opb} : '0);
        mul_next = {mul_sum[WIDTH-1:0], base[WIDTH-1:0]} >> 1;
        mul_next[2*WIDTH-1] = mul_sum[WIDTH];

        // Divide: shifted remainder needs WIDTH+1 bits; a clear top bit of the
        // difference means the trial subtraction fits.
        div_rs   = {base[2*WIDTH-1:WIDTH], base[WIDTH-1]};
        div_diff = div_rs - {1'b0, opb};
        div_ge   = ~div_diff[WIDTH];
        div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
        div_quo  = base[WIDTH-1:0] << 1;
        div_quo[0] = div_ge;

        step = mode ? {div_rem, div_quo} : mul_next;
    end

    // Load on start, then iterate until the remaining count runs out.
    always_comb begin
        acc_d  = acc_q;
        b_d    = b_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (start) begin
            acc_d  = step;
            b_d    = b;
            div_d  = is_div;
            cnt_d  = CW'(WIDTH - 1);
            done_d = (WIDTH == 1);
        end else if (cnt_q != '0) begin
            acc_d  = step;
            cnt_d  = cnt_q - CW'(1);
            done_d = (cnt_q == CW'(1));
        end
    end

    // Iteration state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            b_q    <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            b_q    <= b_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done   = done_q;
    assign result = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes on both sides. Single-cycle ops
// complete on the accept edge; MUL/DIV run on the iterative sub-unit.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned OPW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [OPW-1:0]       opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 zero,
    output logic                 div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               dbz_q, dbz_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               op_is_div;
    logic               b_is_zero;
    logic               md_start;
    logic               md_done;
    logic [2*WIDTH-1:0] md_result;

    logic [WIDTH:0]     sc_sum;
    logic [WIDTH-1:0]   sc_val;
    logic               sc_carry;
    logic               sc_dbz;

    assign accept    = in_valid && (state_q == IDLE);
    assign op_is_div = (opcode == OPW'(OP_DIV));
    assign b_is_zero = (b == '0);
    assign md_start  = accept && is_iterative(32'(opcode)) && !(op_is_div && b_is_zero);

    seq_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (op_is_div),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_result)
    );

    // Single-cycle datapath: WIDTH-bit result plus carry/borrow from the extended op.
    always_comb begin
        sc_sum   = '0;
        sc_val   = '0;
        sc_carry = 1'b0;
        sc_dbz   = 1'b0;
        case (opcode)
            OPW'(OP_ADD): begin
                sc_sum   = {1'b0, a} + {1'b0, b};
                sc_val   = sc_sum[WIDTH-1:0];
                sc_carry = sc_sum[WIDTH];
            end
            OPW'(OP_SUB): begin
                sc_sum   = {1'b0, a} - {1'b0, b};
                sc_val   = sc_sum[WIDTH-1:0];
                sc_carry = sc_sum[WIDTH];
            end
            OPW'(OP_INC): begin
                sc_sum   = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
                sc_val   = sc_sum[WIDTH-1:0];
                sc_carry = sc_sum[WIDTH];
            end
            OPW'(OP_DEC): begin
                sc_sum   = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
                sc_val   = sc_sum[WIDTH-1:0];
                sc_carry = sc_sum[WIDTH];
            end
            OPW'(OP_AND): sc_val = a & b;
            OPW'(OP_OR):  sc_val = a | b;
            OPW'(OP_XOR): sc_val = a ^ b;
            OPW'(OP_NOT): sc_val = ~a;
            OPW'(OP_DIV): sc_dbz = b_is_zero;
            default:      sc_val = '0;
        endcase
    end

    // Handshake FSM next state, iteration counter and output register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (md_start) begin
                        state_d = CALC;
                        cnt_d   = CW'(WIDTH);
                    end else begin
                        state_d     = DONE;
                        result_d    = (2*WIDTH)'(sc_val);
                        carry_d     = sc_carry;
                        zero_d      = ((2*WIDTH)'(sc_val) == '0);
                        dbz_d       = sc_dbz;
                        out_valid_d = 1'b1;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q - CW'(1);
                // The sub-unit finishes exactly as the counter steps to zero.
                if (md_done) begin
                    state_d     = DONE;
                    result_d    = md_result;
                    carry_d     = 1'b0;
                    zero_d      = (md_result == '0);
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign carry       = carry_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed cases followed by random
// operations compared against an arithmetic reference model.
module tb_seq_alu;

    localparam int unsigned W = 19;
    localparam longint unsigned MASK = (64'd1 << W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [4:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   result;
    logic             carry;
    logic             zero;
    logic             div_by_zero;

    int               n_checks = 0;
    int               n_fail   = 0;
    longint unsigned  last_res;

    seq_alu #(
        .WIDTH (W),
        .OPW   (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .opcode      (opcode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .carry       (carry),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the opcode table, using wide integer arithmetic.
    function automatic void model(input int op, input longint unsigned av, input longint unsigned bv,
                                  output longint unsigned res, output bit c, output bit z,
                                  output bit d, output int lat);
        res = 0; c = 0; d = 0; lat = 1;
        case (op)
            0: begin res = (av + bv) & MASK; c = ((av + bv) > MASK); end
            1: begin res = (av - bv) & MASK; c = (av < bv); end
            2: begin res = av * bv; lat = W + 1; end
            3: begin
                if (bv == 0) d = 1;
                else begin
                    res = ((av % bv) << W) | (av / bv);
                    lat = W + 1;
                end
            end
            4: begin res = (av + 1) & MASK; c = (av == MASK); end
            5: begin res = (av - 1) & MASK; c = (av == 0); end
            6: res = av & bv;
            7: res = av | bv;
            8: res = av ^ bv;
            9: res = (~av) & MASK;
            default: res = 0;
        endcase
        z = (res == 0);
    endfunction

    function automatic longint unsigned pick();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return MASK;
            2:       return 1;
            default: return longint'($urandom) & MASK;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_op(input string tag, input int op, input longint unsigned av,
                         input longint unsigned bv, input int hold, input bit intrude);
        longint unsigned e_res;
        bit e_c, e_z, e_d;
        int e_lat;
        int lat;
        model(op, av, bv, e_res, e_c, e_z, e_d, e_lat);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        a        = W'(av);
        b        = W'(bv);
        opcode   = 5'(op);
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        opcode   = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 4 * W) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_result"}, result, e_res);
        chk({tag, "_carry"}, carry, e_c);
        chk({tag, "_zero"}, zero, e_z);
        chk({tag, "_dbz"}, div_by_zero, e_d);
        last_res = result;
        for (int i = 0; i < hold; i++) begin
            if (intrude) begin
                in_valid = 1'b1;
                a        = W'($urandom);
                b        = W'($urandom);
                opcode   = 5'd0;
            end
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_result"}, result, e_res);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, out_valid, 0);
        chk({tag, "_post_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int op;
        longint unsigned av, bv;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_carry", carry, 0);
        chk("rst_zero", zero, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        do_op("add_ovf", 0, 64'h7FFFF, 1, 0, 0);
        chk("add_ovf_const", last_res, 0);
        do_op("mul_small", 2, 3, 4, 0, 0);
        chk("mul_small_const", last_res, 12);
        do_op("mul_max", 2, 64'h7FFFF, 64'h7FFFF, 1, 0);
        chk("mul_max_const", last_res, 64'h3FFFF00001);
        do_op("div_9_3", 3, 9, 3, 0, 0);
        chk("div_9_3_const", last_res, 3);
        do_op("div_10_3", 3, 10, 3, 2, 0);
        chk("div_10_3_const", last_res, 64'h80003);
        do_op("div_by_0", 3, 9, 0, 0, 0);
        do_op("sub_hold", 1, 5, 3, 5, 1);
        chk("sub_hold_const", last_res, 2);
        do_op("sub_borrow", 1, 3, 5, 0, 0);
        do_op("inc_max", 4, MASK, 0, 0, 0);
        do_op("dec_zero", 5, 0, 0, 0, 0);
        do_op("and", 6, 64'h5A5A5, 64'h3C3C3, 0, 0);
        do_op("or", 7, 64'h5A5A5, 64'h3C3C3, 0, 0);
        do_op("xor", 8, 64'h5A5A5, 64'h3C3C3, 0, 0);
        do_op("not", 9, 64'h12345, 0, 0, 0);
        do_op("undef", 31, 64'h12345, 64'h54321, 0, 0);

        // Reset in the fifth CALC cycle of a multiply discards it.
        in_valid = 1'b1;
        a        = W'(3);
        b        = W'(4);
        opcode   = 5'd2;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midreset_busy", in_ready, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_result", result, 0);
        chk("midreset_in_ready", in_ready, 1);
        repeat (25) @(negedge clk);
        chk("midreset_no_late_valid", out_valid, 0);
        do_op("add_after_reset", 0, 1, 2, 0, 0);
        chk("add_after_reset_const", last_res, 3);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 12);
            av = pick();
            bv = pick();
            do_op($sformatf("rnd%0d_op%0d", i, op), op, av, bv, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
